// File: rtl/fight_round_ctrl.sv
// Round sequencer for the fighter game: round FSM, countdown/round timers,
// both health registers and round-robin arbitration of the shared hit path.
module fight_round_ctrl #(
    parameter int MAX_HEALTH        = 100,
    parameter int FRAMES_PER_SEC    = 60,
    parameter int ROUND_SECONDS     = 99,
    parameter int COUNTDOWN_SECONDS = 3,
    parameter int KO_HOLD_FRAMES    = 120
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Soft_Reset,
    input  logic       frame_clk,
    input  logic       start,
    input  logic       p1_hit_req,
    input  logic [7:0] p1_damage,
    input  logic       p2_hit_req,
    input  logic [7:0] p2_damage,
    output logic       p1_hit_ack,
    output logic       p2_hit_ack,
    output logic [7:0] p1_health,
    output logic [7:0] p2_health,
    output logic [6:0] timer_sec,
    output logic [2:0] state,
    output logic       move_enable,
    output logic [1:0] winner,
    output logic       frame_tick
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_FIGHT     = 3'd2,
        ST_KO        = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    typedef enum logic {
        PTR_P1 = 1'b0,
        PTR_P2 = 1'b1
    } side_e;

    localparam logic [7:0] HEALTH_INIT = 8'(MAX_HEALTH);
    localparam logic [7:0] FRAME_LAST  = 8'(FRAMES_PER_SEC - 1);
    localparam logic [6:0] ROUND_INIT  = 7'(ROUND_SECONDS);
    localparam logic [6:0] COUNT_INIT  = 7'(COUNTDOWN_SECONDS);
    localparam logic [7:0] HOLD_LAST   = 8'(KO_HOLD_FRAMES - 1);

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    state_e     state_q, state_d;
    side_e      ptr_q, ptr_d;
    logic [7:0] p1_health_q, p1_health_d;
    logic [7:0] p2_health_q, p2_health_d;
    logic [6:0] timer_q, timer_d;
    logic [1:0] winner_q, winner_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       p1_ack_q, p1_ack_d;
    logic       p2_ack_q, p2_ack_d;
    logic       move_en_q, move_en_d;
    logic       frame_tick_q, frame_tick_d;
    logic [2:0] frame_sync_q, frame_sync_d;
    logic       start_q, start_d;

    logic start_rise, tick, round_over, load_round;
    logic p1_elig, p2_elig, p1_grant, p2_grant;

    function automatic logic [7:0] sat_sub(input logic [7:0] health, input logic [7:0] damage);
        return (health > damage) ? health - damage : 8'd0;
    endfunction

    // frame_sync_q[1] is the synchronised VS; [2] is its previous value for edge detection.
    assign tick       = frame_sync_q[1] & ~frame_sync_q[2];
    assign start_rise = start & ~start_q;
    assign round_over = (p1_health_q == 8'd0) || (p2_health_q == 8'd0) || (timer_q == 7'd0);

    assign p1_elig  = p1_hit_req & ~p1_ack_q;
    assign p2_elig  = p2_hit_req & ~p2_ack_q;
    assign p1_grant = p1_elig & (~p2_elig | (ptr_q == PTR_P1));
    assign p2_grant = p2_elig & ~p1_grant;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_d      = state_q;
        ptr_d        = ptr_q;
        p1_health_d  = p1_health_q;
        p2_health_d  = p2_health_q;
        timer_d      = timer_q;
        winner_d     = winner_q;
        frame_cnt_d  = frame_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        p1_ack_d     = 1'b0;
        p2_ack_d     = 1'b0;
        frame_sync_d = {frame_sync_q[1:0], frame_clk};
        start_d      = start;
        frame_tick_d = tick;
        load_round   = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_rise) begin
                    state_d    = ST_COUNTDOWN;
                    load_round = 1'b1;
                end
            end

            ST_COUNTDOWN: begin
                if (tick) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = 8'd0;
                        if (timer_q == 7'd1) begin
                            state_d = ST_FIGHT;
                            timer_d = ROUND_INIT;
                        end else begin
                            timer_d = timer_q - 7'd1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end

            ST_FIGHT: begin
                if (round_over) begin
                    state_d     = ST_KO;
                    frame_cnt_d = 8'd0;
                    hold_cnt_d  = 8'd0;
                    if (p1_health_q == 8'd0 && p2_health_q == 8'd0) winner_d = WIN_DRAW;
                    else if (p2_health_q == 8'd0)                    winner_d = WIN_P1;
                    else if (p1_health_q == 8'd0)                    winner_d = WIN_P2;
                    else if (p1_health_q > p2_health_q)              winner_d = WIN_P1;
                    else if (p2_health_q > p1_health_q)              winner_d = WIN_P2;
                    else                                             winner_d = WIN_DRAW;
                end else begin
                    if (tick) begin
                        if (frame_cnt_q == FRAME_LAST) begin
                            frame_cnt_d = 8'd0;
                            timer_d     = timer_q - 7'd1;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end
                    // A contested cycle hands priority to the side that just lost.
                    if (p1_elig && p2_elig) ptr_d = (ptr_q == PTR_P1) ? PTR_P2 : PTR_P1;
                    if (p1_grant) begin
                        p1_ack_d    = 1'b1;
                        p2_health_d = sat_sub(p2_health_q, p1_damage);
                    end
                    if (p2_grant) begin
                        p2_ack_d    = 1'b1;
                        p1_health_d = sat_sub(p1_health_q, p2_damage);
                    end
                end
            end

            ST_KO: begin
                if (tick) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = ST_GAME_OVER;
                        hold_cnt_d = 8'd0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (load_round) begin
            p1_health_d = HEALTH_INIT;
            p2_health_d = HEALTH_INIT;
            frame_cnt_d = 8'd0;
            timer_d     = COUNT_INIT;
            winner_d    = WIN_NONE;
        end

        move_en_d = (state_d == ST_FIGHT);
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!Reset_n || Soft_Reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= PTR_P1;
            p1_health_q  <= HEALTH_INIT;
            p2_health_q  <= HEALTH_INIT;
            timer_q      <= ROUND_INIT;
            winner_q     <= WIN_NONE;
            frame_cnt_q  <= 8'd0;
            hold_cnt_q   <= 8'd0;
            p1_ack_q     <= 1'b0;
            p2_ack_q     <= 1'b0;
            move_en_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            frame_sync_q <= 3'b000;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            p1_health_q  <= p1_health_d;
            p2_health_q  <= p2_health_d;
            timer_q      <= timer_d;
            winner_q     <= winner_d;
            frame_cnt_q  <= frame_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            p1_ack_q     <= p1_ack_d;
            p2_ack_q     <= p2_ack_d;
            move_en_q    <= move_en_d;
            frame_tick_q <= frame_tick_d;
            frame_sync_q <= frame_sync_d;
            start_q      <= start_d;
        end
    end

    assign p1_hit_ack  = p1_ack_q;
    assign p2_hit_ack  = p2_ack_q;
    assign p1_health   = p1_health_q;
    assign p2_health   = p2_health_q;
    assign timer_sec   = timer_q;
    assign state       = state_q;
    assign move_enable = move_en_q;
    assign winner      = winner_q;
    assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_fight_round_ctrl.sv
// Self-checking bench for fight_round_ctrl: directed vector table, hand-written
// timer/KO/reset sequences and randomized hit traffic against a behavioural model.
module tb_fight_round_ctrl;

    logic       Clk, Reset_n, Soft_Reset, frame_clk, start;
    logic       p1_hit_req, p2_hit_req;
    logic [7:0] p1_damage, p2_damage;
    logic       p1_hit_ack, p2_hit_ack;
    logic [7:0] p1_health, p2_health;
    logic [6:0] timer_sec;
    logic [2:0] state;
    logic       move_enable;
    logic [1:0] winner;
    logic       frame_tick;

    int n_checks = 0;
    int n_fail   = 0;
    bit ack_seen  = 0;
    bit tick_seen = 0;

    fight_round_ctrl #(
        .MAX_HEALTH(100), .FRAMES_PER_SEC(2), .ROUND_SECONDS(99),
        .COUNTDOWN_SECONDS(3), .KO_HOLD_FRAMES(4)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Soft_Reset(Soft_Reset), .frame_clk(frame_clk),
        .start(start), .p1_hit_req(p1_hit_req), .p1_damage(p1_damage),
        .p2_hit_req(p2_hit_req), .p2_damage(p2_damage), .p1_hit_ack(p1_hit_ack),
        .p2_hit_ack(p2_hit_ack), .p1_health(p1_health), .p2_health(p2_health),
        .timer_sec(timer_sec), .state(state), .move_enable(move_enable),
        .winner(winner), .frame_tick(frame_tick)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish within 2 ms");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
        if (p1_hit_ack || p2_hit_ack) ack_seen = 1;
        if (frame_tick) tick_seen = 1;
    endtask

    task automatic frame_pulse();
        frame_clk = 1'b1;
        repeat (3) step();
        frame_clk = 1'b0;
        repeat (2) step();
    endtask

    task automatic drive_hits(input bit r1, input int d1, input bit r2, input int d2);
        p1_hit_req = r1;
        p1_damage  = 8'(d1);
        p2_hit_req = r2;
        p2_damage  = 8'(d2);
    endtask

    // Behavioural model of the fight: healths as plain integers, fairness as
    // "who should win the next contested cycle".
    int m_h1, m_h2, m_win;
    bit m_a1, m_a2, m_done;
    bit m_prefer_p2 = 0;

    task automatic model_cycle(input bit r1, input int d1, input bit r2, input int d2);
        bit e1, e2, g1, g2;
        if (m_h1 == 0 || m_h2 == 0) begin
            m_done = 1;
            m_win  = (m_h1 == 0 && m_h2 == 0) ? 3 : (m_h2 == 0) ? 1 : 2;
            m_a1   = 0;
            m_a2   = 0;
        end else begin
            e1 = r1 && !m_a1;
            e2 = r2 && !m_a2;
            if (e1 && e2) begin
                g1 = !m_prefer_p2;
                g2 = m_prefer_p2;
                m_prefer_p2 = !m_prefer_p2;
            end else begin
                g1 = e1;
                g2 = e2;
            end
            if (g1) m_h2 = (m_h2 - d1 < 0) ? 0 : m_h2 - d1;
            if (g2) m_h1 = (m_h1 - d2 < 0) ? 0 : m_h1 - d2;
            m_a1 = g1;
            m_a2 = g2;
        end
    endtask

    typedef struct {
        bit r1; int d1; bit r2; int d2;
        bit a1; bit a2; int h1; int h2; int st; int win;
    } vec_t;

    vec_t vecs[17];

    task automatic start_round();
        start = 1'b1;
        step();
        check("round_start_state", state, 1);
        start = 1'b0;
        repeat (6) frame_pulse();
        check("round_fight_state", state, 2);
        check("round_fight_timer", timer_sec, 99);
    endtask

    initial begin
        vecs[0]  = '{1, 10, 1, 15, 1, 0, 100, 90, 2, 0};
        vecs[1]  = '{0,  0, 1, 15, 0, 1,  85, 90, 2, 0};
        vecs[2]  = '{0,  0, 0,  0, 0, 0,  85, 90, 2, 0};
        vecs[3]  = '{1, 10, 1, 15, 0, 1,  70, 90, 2, 0};
        vecs[4]  = '{1, 10, 0,  0, 1, 0,  70, 80, 2, 0};
        vecs[5]  = '{0,  0, 0,  0, 0, 0,  70, 80, 2, 0};
        vecs[6]  = '{1,  0, 0,  0, 1, 0,  70, 80, 2, 0};
        vecs[7]  = '{0,  0, 0,  0, 0, 0,  70, 80, 2, 0};
        vecs[8]  = '{1,  5, 0,  0, 1, 0,  70, 75, 2, 0};
        vecs[9]  = '{1,  5, 0,  0, 0, 0,  70, 75, 2, 0};
        vecs[10] = '{1,  5, 0,  0, 1, 0,  70, 70, 2, 0};
        vecs[11] = '{0,  0, 0,  0, 0, 0,  70, 70, 2, 0};
        vecs[12] = '{1, 65, 0,  0, 1, 0,  70,  5, 2, 0};
        vecs[13] = '{0,  0, 0,  0, 0, 0,  70,  5, 2, 0};
        vecs[14] = '{1, 20, 0,  0, 1, 0,  70,  0, 2, 0};
        vecs[15] = '{0,  0, 1, 15, 0, 0,  70,  0, 3, 1};
        vecs[16] = '{0,  0, 1, 15, 0, 0,  70,  0, 3, 1};

        Reset_n = 1'b0; Soft_Reset = 1'b0; frame_clk = 1'b0; start = 1'b0;
        drive_hits(0, 0, 0, 0);
        repeat (2) step();
        Reset_n = 1'b1;
        step();
        check("rst_state", state, 0);
        check("rst_p1_health", p1_health, 100);
        check("rst_p2_health", p2_health, 100);
        check("rst_timer", timer_sec, 99);
        check("rst_winner", winner, 0);
        check("rst_acks", {p1_hit_ack, p2_hit_ack}, 0);
        check("rst_move_enable", move_enable, 0);
        check("rst_frame_tick", frame_tick, 0);

        // frame_tick appears on the third edge after frame_clk rises, for one cycle
        frame_clk = 1'b1;
        repeat (2) step();
        check("tick_lat_early", frame_tick, 0);
        step();
        check("tick_lat_on", frame_tick, 1);
        frame_clk = 1'b0;
        step();
        check("tick_one_cycle", frame_tick, 0);
        step();
        check("tick_idle_state", state, 0);

        // countdown with 2 ticks per second from 3
        start = 1'b1;
        step();
        start = 1'b0;
        check("cd_state", state, 1);
        check("cd_timer", timer_sec, 3);
        frame_pulse();
        check("cd_tick1_timer", timer_sec, 3);
        frame_pulse();
        check("cd_tick2_timer", timer_sec, 2);
        repeat (2) frame_pulse();
        check("cd_tick4_timer", timer_sec, 1);
        check("cd_tick4_move", move_enable, 0);
        frame_pulse();
        check("cd_tick5_state", state, 1);
        frame_pulse();
        check("cd_tick6_state", state, 2);
        check("cd_tick6_timer", timer_sec, 99);
        check("cd_tick6_move", move_enable, 1);

        // arbitration, saturation and KO vectors
        for (int i = 0; i < 17; i++) begin
            drive_hits(vecs[i].r1, vecs[i].d1, vecs[i].r2, vecs[i].d2);
            step();
            check($sformatf("vec%0d_p1_ack", i), p1_hit_ack, 32'(vecs[i].a1));
            check($sformatf("vec%0d_p2_ack", i), p2_hit_ack, 32'(vecs[i].a2));
            check($sformatf("vec%0d_p1_health", i), p1_health, vecs[i].h1);
            check($sformatf("vec%0d_p2_health", i), p2_health, vecs[i].h2);
            check($sformatf("vec%0d_state", i), state, vecs[i].st);
            check($sformatf("vec%0d_winner", i), winner, vecs[i].win);
            check($sformatf("vec%0d_move", i), move_enable, 32'(vecs[i].st == 2));
        end

        // KO hold with a p2 request held: never acked, GAME_OVER on 4th tick
        ack_seen = 0;
        repeat (3) frame_pulse();
        check("ko_hold3_state", state, 3);
        frame_pulse();
        check("ko_hold4_state", state, 4);
        check("ko_no_ack", ack_seen, 0);
        check("go_winner_hold", winner, 1);
        drive_hits(0, 0, 0, 0);

        // timeout round with start held high throughout
        start = 1'b1;
        step();
        check("to_cd_state", state, 1);
        check("to_cd_p2_health", p2_health, 100);
        repeat (6) frame_pulse();
        check("to_fight_state", state, 2);
        repeat (196) frame_pulse();
        check("to_timer_1", timer_sec, 1);
        frame_pulse();
        frame_clk = 1'b1;
        repeat (3) step();
        check("to_timer_0", timer_sec, 0);
        check("to_state_still_fight", state, 2);
        frame_clk = 1'b0;
        step();
        check("to_ko_state", state, 3);
        check("to_ko_winner", winner, 3);
        check("to_ko_move", move_enable, 0);
        step();
        repeat (3) frame_pulse();
        check("to_hold3_state", state, 3);
        frame_pulse();
        check("to_game_over", state, 4);
        repeat (3) step();
        check("to_start_held_no_restart", state, 4);
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        check("restart_state", state, 1);
        check("restart_p1_health", p1_health, 100);
        check("restart_p2_health", p2_health, 100);
        check("restart_timer", timer_sec, 3);
        check("restart_winner", winner, 0);
        start = 1'b0;

        // Soft_Reset during countdown
        frame_pulse();
        Soft_Reset = 1'b1;
        step();
        Soft_Reset = 1'b0;
        check("soft_rst_state", state, 0);
        check("soft_rst_timer", timer_sec, 99);
        check("soft_rst_winner", winner, 0);

        // frame_clk pulse entirely inside Reset_n low leaves no tick behind
        Reset_n = 1'b0;
        step();
        frame_clk = 1'b1;
        repeat (2) step();
        frame_clk = 1'b0;
        repeat (2) step();
        Reset_n = 1'b1;
        tick_seen = 0;
        repeat (6) step();
        check("rst_pulse_no_tick", tick_seen, 0);

        // randomized hit traffic against the model
        for (int r = 0; r < 4; r++) begin
            start_round();
            m_h1 = 100; m_h2 = 100; m_a1 = 0; m_a2 = 0; m_done = 0; m_win = 0;
            for (int c = 0; c < 400 && !m_done; c++) begin
                bit r1, r2;
                int d1, d2;
                r1 = 1'($urandom_range(0, 1));
                r2 = 1'($urandom_range(0, 1));
                d1 = int'($urandom_range(0, 40));
                d2 = int'($urandom_range(0, 40));
                drive_hits(r1, d1, r2, d2);
                model_cycle(r1, d1, r2, d2);
                step();
                check("rand_p1_ack", p1_hit_ack, 32'(m_a1));
                check("rand_p2_ack", p2_hit_ack, 32'(m_a2));
                check("rand_p1_health", p1_health, m_h1);
                check("rand_p2_health", p2_health, m_h2);
                check("rand_state", state, m_done ? 3 : 2);
            end
            check("rand_ko_reached", state, 3);
            check("rand_winner", winner, m_win);
            drive_hits(0, 0, 0, 0);
            repeat (4) frame_pulse();
            check("rand_game_over", state, 4);
        end

        // Reset_n for two cycles in the middle of a fight
        start_round();
        drive_hits(0, 0, 1, 15);
        step();
        check("mid_hit_p1_health", p1_health, 85);
        drive_hits(0, 0, 0, 0);
        Reset_n = 1'b0;
        repeat (2) step();
        check("mid_rst_state", state, 0);
        check("mid_rst_p1_health", p1_health, 100);
        check("mid_rst_p2_health", p2_health, 100);
        check("mid_rst_timer", timer_sec, 99);
        check("mid_rst_winner", winner, 0);
        check("mid_rst_acks", {p1_hit_ack, p2_hit_ack}, 0);
        check("mid_rst_move", move_enable, 0);
        Reset_n = 1'b1;
        step();
        check("mid_rst_release_state", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fight_round_ctrl.md
Name: fight_round_ctrl

Overview:
Round sequencer for the fighter game. It sits between the frame timing (VGA_VS), the player and npc movement blocks and the colour/HUD logic. It owns the round state machine, countdown and round timers, and both health registers. It also arbitrates hit requests from the two fighters, which share the single health-update path.

Parameters:
MAX_HEALTH, 100, health loaded at round start (8-bit, ≤255)
FRAMES_PER_SEC, 60, frame ticks per timer second (1..255)
ROUND_SECONDS, 99, round length in seconds (1..127)
COUNTDOWN_SECONDS, 3, pre-fight countdown in seconds (1..127)
KO_HOLD_FRAMES, 120, frame ticks spent in KO before GAME_OVER (1..255)

Ports:
Clk  in  1  system clock (50 MHz)
Reset_n  in  1  synchronous active-low reset
Soft_Reset  in  1  active-high, synchronous; returns to IDLE
frame_clk  in  1  VGA_VS, asynchronous to Clk
start  in  1  level start request from keycode decode
p1_hit_req  in  1  player landed hit on npc
p1_damage  in  8  damage to npc
p2_hit_req  in  1  npc landed hit on player
p2_damage  in  8  damage to player
p1_hit_ack  out  1  one-cycle grant for p1 hit
p2_hit_ack  out  1  one-cycle grant for p2 hit
p1_health  out  8  player health
p2_health  out  8  npc health
timer_sec  out  7  countdown value in COUNTDOWN, else round timer
state  out  3  IDLE=0, COUNTDOWN=1, FIGHT=2, KO=3, GAME_OVER=4
move_enable  out  1  high only in FIGHT
winner  out  2  00 none, 01 player, 10 npc, 11 draw
frame_tick  out  1  one-Clk pulse per frame

Behaviour:
- Reset (Reset_n=0 at posedge Clk) sets all outputs and registers to their reset values:
  - state=IDLE; p1_health=p2_health=MAX_HEALTH; timer_sec=ROUND_SECONDS; winner=00.
  - Acks, move_enable and frame_tick =0; sync flops =0; frame/hold counters =0.
  - Round-robin pointer = p1.
- Soft_Reset=1 has the same effect, lower priority than Reset_n.
- frame_clk passes through a 2-flop synchroniser. A rising edge of the synchronised signal gives frame_tick=1 for exactly one cycle. Latency from frame_clk rise to frame_tick is 3 Clk cycles.
- start goes through a 1-flop delay; start_rise = start & ~start_q.
- IDLE: on start_rise -> COUNTDOWN.
- Entering COUNTDOWN loads: healths=MAX_HEALTH, frame_cnt=0, timer_sec=COUNTDOWN_SECONDS, winner=00.
- Second counting (COUNTDOWN and FIGHT), on each frame_tick:
  - if frame_cnt==FRAMES_PER_SEC-1: frame_cnt=0 and timer_sec decrements;
  - otherwise frame_cnt increments.
- COUNTDOWN: the decrement that would reach 0 instead goes to FIGHT, with timer_sec=ROUND_SECONDS and frame_cnt=0. FIGHT is therefore entered on the edge processing the (COUNTDOWN_SECONDS*FRAMES_PER_SEC)-th tick.
- FIGHT, end-of-round check on registered values every cycle:
  - if p1_health==0, p2_health==0 or timer_sec==0: go to KO next edge. No grant is issued in that cycle and frame_cnt is cleared.
  - Winner: both healths 0 -> 11; p2 zero -> 01; p1 zero -> 10.
  - On timeout with both nonzero: higher health wins, equal -> 11.
- FIGHT arbitration:
  - A requester is eligible if its req=1 and its ack is not currently 1.
  - One eligible requester -> granted.
  - Both eligible -> the pointer side is granted and the pointer flips to the other side.
  - Grant at edge N: ack=1 during cycle N+1, and the target health is updated at edge N: health = (health > damage) ? health-damage : 0 (saturating).
  - damage=0 is acked with no change.
  - An ungranted request stays pending while held high.
  - Requesters must drop req in their ack cycle; otherwise they are re-eligible the cycle after.
- Hits outside FIGHT are never acked.
- KO: move_enable=0; count frame_ticks; on the KO_HOLD_FRAMES-th tick -> GAME_OVER.
- GAME_OVER: outputs hold. start_rise -> COUNTDOWN (reload as above).
- move_enable = (state==FIGHT), registered with state.
- Illegal state encodings return to IDLE.

Test Plan:
1. Reset_n=0 for 2 cycles mid-FIGHT -> state=0, healths=100/100, timer_sec=99, winner=00, acks=0, move_enable=0.
2. FRAMES_PER_SEC=2, COUNTDOWN_SECONDS=3:
   - start_rise -> state=1, timer_sec=3;
   - after the 2nd tick timer_sec=2, after the 4th timer_sec=1;
   - the 6th tick gives state=2, timer_sec=99, move_enable=1.
3. In FIGHT, p1_hit_req with dmg 10 and p2_hit_req with dmg 15 asserted together, both held:
   - p1_hit_ack next cycle, p2_health=90;
   - p2_hit_ack the following cycle, p1_health=85;
   - repeat simultaneously -> p2 granted first.
4. p2_health=5, p1 dmg 20 -> p2_health=0 (no wrap). Next edge: state=3, winner=01, move_enable=0. A p2_hit_req in KO is never acked.
5. ROUND_SECONDS=3, FRAMES_PER_SEC=2, no hits:
   - after 6 ticks timer_sec=0, then state=3, winner=11;
   - KO_HOLD_FRAMES=4 ticks later state=4;
   - start held high gives no restart; a new start_rise -> state=1 with healths 100/100.
6. Soft_Reset pulse in COUNTDOWN -> state=0, timer_sec=99. A frame_clk pulse during Reset_n low produces no frame_tick after release.
